// File: rtl/ffs_event_drain_pkg.sv
// ffs_event_drain_pkg: shared index-width helper and drain FSM state encoding
package ffs_event_drain_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/ffs_event_drain_ffs.sv
// ffs_m: combinational find-first-set, lowest index first unless MSB_FIRST
module ffs_m import ffs_event_drain_pkg::*; #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    found = |vec;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (vec[MSB_FIRST ? i : WIDTH-1-i]) idx = IDX_W'(MSB_FIRST ? i : WIDTH-1-i);
  end
endmodule

// File: rtl/ffs_event_drain.sv
// ffs_event_drain: pending-event collector draining one index per cycle; overflow tracking under FFS_EVENT_DRAIN_OVF_EN
module ffs_event_drain import ffs_event_drain_pkg::*; #(
  parameter int WIDTH = 8,
  localparam int IDX_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] set_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] out_idx_o,
  output logic [WIDTH-1:0] pend_o,
  output logic             ovf_o,
  output logic [7:0]       ovf_cnt_o
);
  logic [WIDTH-1:0] pending, mask;
  logic [0:0]       state;
  logic             found, cap;
  logic [IDX_W-1:0] ffs_idx;
  ffs_m #(WIDTH, 0) u_ffs (.vec(pending), .found(found), .idx(ffs_idx));
  // a capture happens whenever the output slot is free or being freed this cycle
  always_comb begin
    cap = found & ((state == IDLE) | out_ready_i);
    mask = cap ? (WIDTH'(1) << ffs_idx) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else pending <= (pending & ~mask & ~{WIDTH{flush_i}}) | set_i;
  end
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state <= IDLE;
      out_idx_o <= '0;
    end else if (cap) begin
      state <= HOLD;
      out_idx_o <= ffs_idx;
    end else if (out_ready_i) state <= IDLE;
  end
  assign out_valid_o = (state == HOLD);
  assign pend_o = pending;
`ifdef FFS_EVENT_DRAIN_OVF_EN
  logic hit;
  assign hit = |(set_i & pending & ~mask);
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      ovf_o <= 1'b0;
      ovf_cnt_o <= '0;
    end else if (hit) begin
      ovf_o <= 1'b1;
      if (ovf_cnt_o != 8'hff) ovf_cnt_o <= ovf_cnt_o + 8'd1;
    end
  end
`else
  assign ovf_o = 1'b0;
  assign ovf_cnt_o = '0;
`endif
endmodule

// File: tb/tb_ffs_event_drain.sv
// tb_ffs_event_drain: directed vector table plus overflow and full sweep sequences
module tb_ffs_event_drain;
`ifdef FFS_EVENT_DRAIN_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic       clk = 0, rst = 1, flush_i = 0, out_ready_i = 0;
  logic [7:0] set_i = '0;
  logic       out_valid_o, ovf_o;
  logic [2:0] out_idx_o;
  logic [7:0] pend_o, ovf_cnt_o;
  int n_cmp = 0, n_bad = 0;

  ffs_event_drain #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .set_i(set_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_idx_o(out_idx_o),
    .pend_o(pend_o), .ovf_o(ovf_o), .ovf_cnt_o(ovf_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] set;
    logic       rdy, fl, ev;
    logic [2:0] ei;
    logic [7:0] ep;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] s, input logic r, input logic f);
    @(negedge clk);
    set_i = s; out_ready_i = r; flush_i = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev, cnt;
    logic [7:0] seen;
    // test 1: A4 drains as 2,5,7
    vecs.push_back(vec_t'{8'hA4, 1, 0, 0, 0, 8'hA4});
    vecs.push_back(vec_t'{8'h00, 1, 0, 1, 2, 8'hA0});
    vecs.push_back(vec_t'{8'h00, 1, 0, 1, 5, 8'h80});
    vecs.push_back(vec_t'{8'h00, 1, 0, 1, 7, 8'h00});
    vecs.push_back(vec_t'{8'h00, 1, 0, 0, 0, 8'h00});
    // test 2: stall holds 0; lower event 1 waits; then 1,7
    vecs.push_back(vec_t'{8'h81, 0, 0, 0, 0, 8'h81});
    vecs.push_back(vec_t'{8'h00, 0, 0, 1, 0, 8'h80});
    vecs.push_back(vec_t'{8'h02, 0, 0, 1, 0, 8'h82});
    vecs.push_back(vec_t'{8'h00, 0, 0, 1, 0, 8'h82});
    vecs.push_back(vec_t'{8'h00, 1, 0, 1, 1, 8'h80});
    vecs.push_back(vec_t'{8'h00, 1, 0, 1, 7, 8'h00});
    vecs.push_back(vec_t'{8'h00, 1, 0, 0, 0, 8'h00});
    // test 3: re-arm of held index 3
    vecs.push_back(vec_t'{8'h08, 0, 0, 0, 0, 8'h08});
    vecs.push_back(vec_t'{8'h00, 0, 0, 1, 3, 8'h00});
    vecs.push_back(vec_t'{8'h08, 0, 0, 1, 3, 8'h08});
    vecs.push_back(vec_t'{8'h00, 1, 0, 1, 3, 8'h00});
    vecs.push_back(vec_t'{8'h00, 1, 0, 0, 0, 8'h00});
    // set of the bit being captured in the same cycle re-pends it
    vecs.push_back(vec_t'{8'h01, 0, 0, 0, 0, 8'h01});
    vecs.push_back(vec_t'{8'h00, 0, 0, 1, 0, 8'h00});
    vecs.push_back(vec_t'{8'h04, 0, 0, 1, 0, 8'h04});
    vecs.push_back(vec_t'{8'h04, 1, 0, 1, 2, 8'h04});
    vecs.push_back(vec_t'{8'h00, 1, 0, 1, 2, 8'h00});
    vecs.push_back(vec_t'{8'h00, 1, 0, 0, 0, 8'h00});
    // test 5: flush with same-cycle set 40
    vecs.push_back(vec_t'{8'h0C, 0, 0, 0, 0, 8'h0C});
    vecs.push_back(vec_t'{8'h00, 0, 0, 1, 2, 8'h08});
    vecs.push_back(vec_t'{8'h40, 0, 1, 0, 0, 8'h40});
    vecs.push_back(vec_t'{8'h00, 1, 0, 1, 6, 8'h00});
    vecs.push_back(vec_t'{8'h00, 1, 0, 0, 0, 8'h00});

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid_o), 0);
    check("rst_idx", 32'(out_idx_o), 0);
    check("rst_pend", 32'(pend_o), 0);
    check("rst_ovf", 32'(ovf_o), 0);
    check("rst_cnt", 32'(ovf_cnt_o), 0);
    @(negedge clk) rst = 0;

    foreach (vecs[i]) begin
      step(vecs[i].set, vecs[i].rdy, vecs[i].fl);
      check($sformatf("v%0d_valid", i), 32'(out_valid_o), 32'(vecs[i].ev));
      if (vecs[i].ev) check($sformatf("v%0d_idx", i), 32'(out_idx_o), 32'(vecs[i].ei));
      check($sformatf("v%0d_pend", i), 32'(pend_o), 32'(vecs[i].ep));
      check($sformatf("v%0d_ovf", i), 32'(ovf_o), 0);
    end

    // test 4: overflow on a still-pending bit, saturation, flush clear
    step(8'h11, 0, 0);
    step(8'h00, 0, 0);
    check("ovf_hold_idx", 32'(out_idx_o), 0);
    check("ovf_pend", 32'(pend_o), 32'h10);
    step(8'h10, 0, 0);
    check("ovf_set", 32'(ovf_o), 32'(OVF));
    check("ovf_cnt1", 32'(ovf_cnt_o), OVF ? 1 : 0);
    repeat (300) step(8'h10, 0, 0);
    check("ovf_sat", 32'(ovf_cnt_o), OVF ? 255 : 0);
    check("ovf_sat_idx", 32'(out_idx_o), 0);
    step(8'h00, 0, 1);
    check("flush_ovf", 32'(ovf_o), 0);
    check("flush_cnt", 32'(ovf_cnt_o), 0);
    check("flush_valid", 32'(out_valid_o), 0);
    check("flush_pend", 32'(pend_o), 0);

    // test 6: every pattern drains ascending, once per bit
    for (int v = 0; v < 256; v++) begin
      prev = -1; cnt = 0; seen = '0;
      step(8'(v), 1, 0);
      for (int c = 0; c < 12; c++) begin
        step(8'h00, 1, 0);
        if (out_valid_o) begin
          check($sformatf("sweep%0d_order", v), 32'(int'(out_idx_o) > prev), 1);
          prev = int'(out_idx_o);
          seen[out_idx_o] = 1'b1;
          cnt++;
        end
      end
      check($sformatf("sweep%0d_count", v), cnt, $countones(8'(v)));
      check($sformatf("sweep%0d_seen", v), 32'(seen), v);
      check($sformatf("sweep%0d_pend", v), 32'(pend_o), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
